// File: rtl/axi_lite_master_arbiter.sv
// axi_lite_master_arbiter
// Round-robin arbiter that shares one AXI-Lite master port between NUM_REQ
// command requesters. One command is in flight at a time: grant, issue,
// wait for the response, report it to the owner, then grant again.
//
// Optional feature macro: AXI_ARB_TIMEOUT_EN
//   Defined   : a watchdog aborts a stuck transaction after TIMEOUT_CYCLES
//               cycles in ISSUE/RESP, reports SLVERR and sets timeout_flag.
//   Undefined : no watchdog; timeout_flag is tied low.
//
// Handshake semantics: a transfer on any valid/ready pair happens on the
// rising edge of axi_aclk where both valid and ready are high. A valid, once
// raised, stays high until its transfer. req_ready/rsp_valid are one-cycle
// pulses with no backpressure.
module axi_lite_master_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                                axi_aclk,
  input  logic                                axi_areset,
  // requester side
  input  logic [NUM_REQ-1:0]                  req_valid,
  output logic [NUM_REQ-1:0]                  req_ready,
  input  logic [NUM_REQ-1:0]                  req_write,
  input  logic [NUM_REQ*AXI_ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*AXI_DATA_WIDTH-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]                  rsp_valid,
  output logic [AXI_DATA_WIDTH-1:0]           rsp_rdata,
  output logic [1:0]                          rsp_resp,
  output logic                                busy,
  output logic                                timeout_flag,
  output logic [1:0]                          dbg_state,
  // AXI-Lite master
  output logic [AXI_ADDR_WIDTH-1:0]           m_axi_awaddr,
  output logic [2:0]                          m_axi_awprot,
  output logic                                m_axi_awvalid,
  input  logic                                m_axi_awready,
  output logic [AXI_DATA_WIDTH-1:0]           m_axi_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0]         m_axi_wstrb,
  output logic                                m_axi_wvalid,
  input  logic                                m_axi_wready,
  input  logic [1:0]                          m_axi_bresp,
  input  logic                                m_axi_bvalid,
  output logic                                m_axi_bready,
  output logic [AXI_ADDR_WIDTH-1:0]           m_axi_araddr,
  output logic [2:0]                          m_axi_arprot,
  output logic                                m_axi_arvalid,
  input  logic                                m_axi_arready,
  input  logic [AXI_DATA_WIDTH-1:0]           m_axi_rdata,
  input  logic [1:0]                          m_axi_rresp,
  input  logic                                m_axi_rvalid,
  output logic                                m_axi_rready
);

  localparam int PTR_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t state, state_n;

  logic [PTR_W-1:0]          rr_ptr;
  logic [PTR_W-1:0]          owner_q;
  logic                      write_q;
  logic [AXI_ADDR_WIDTH-1:0] addr_q;
  logic [AXI_DATA_WIDTH-1:0] wdata_q;
  logic                      awvalid_q;
  logic                      wvalid_q;
  logic                      arvalid_q;

  logic [PTR_W-1:0]          grant_idx;
  logic                      grant_found;
  logic                      grant_fire;
  logic [PTR_W:0]            cand_sum;
  logic [PTR_W-1:0]          cand;

  logic                      aw_left;
  logic                      w_left;
  logic                      ar_left;
  logic                      issue_done;
  logic                      rsp_hs;
  logic                      timeout_fire;

  // Round-robin search: first valid requester at or above rr_ptr, wrapping.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand_sum    = '0;
    cand        = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand_sum = {1'b0, rr_ptr} + (PTR_W+1)'(i);
      if (cand_sum >= (PTR_W+1)'(NUM_REQ)) begin
        cand_sum = cand_sum - (PTR_W+1)'(NUM_REQ);
      end
      cand = cand_sum[PTR_W-1:0];
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // No grant while reset is asserted, so no command can slip in during reset.
  assign grant_fire = (state == ST_IDLE) && grant_found && !axi_areset;
  assign req_ready  = grant_fire ? (NUM_REQ'(1) << grant_idx) : '0;

  // A channel is still pending when its valid is up and the slave has not taken it.
  assign aw_left    = awvalid_q && !m_axi_awready;
  assign w_left     = wvalid_q  && !m_axi_wready;
  assign ar_left    = arvalid_q && !m_axi_arready;
  assign issue_done = write_q ? (!aw_left && !w_left) : !ar_left;
  assign rsp_hs     = (state == ST_RESP) && (write_q ? m_axi_bvalid : m_axi_rvalid);

`ifdef AXI_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wd_cnt;
  logic             timeout_flag_q;
  logic             in_wait;

  // The watchdog only fires in a cycle that makes no forward progress, so a
  // response landing on the expiry cycle takes priority.
  assign in_wait      = ((state == ST_ISSUE) && !issue_done) ||
                        ((state == ST_RESP)  && !rsp_hs);
  assign timeout_fire = in_wait && (wd_cnt >= CNT_W'(TIMEOUT_CYCLES - 1));
  assign timeout_flag = timeout_flag_q;

  // Watchdog counter: cleared on grant, counts every ISSUE/RESP cycle.
  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      wd_cnt         <= '0;
      timeout_flag_q <= 1'b0;
    end else begin
      if (grant_fire) begin
        wd_cnt <= '0;
      end else if ((state == ST_ISSUE || state == ST_RESP) &&
                   (wd_cnt != CNT_W'(TIMEOUT_CYCLES))) begin
        wd_cnt <= wd_cnt + 1'b1;
      end
      if (timeout_fire) begin
        timeout_flag_q <= 1'b1;
      end
    end
  end
`else
  assign timeout_fire = 1'b0;
  assign timeout_flag = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE:  if (grant_fire) state_n = ST_ISSUE;
      ST_ISSUE: begin
        if (issue_done)        state_n = ST_RESP;
        else if (timeout_fire) state_n = ST_DONE;
      end
      ST_RESP: begin
        if (rsp_hs)            state_n = ST_DONE;
        else if (timeout_fire) state_n = ST_DONE;
      end
      ST_DONE:  state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  // Command latch, AXI valids and response capture.
  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      rr_ptr    <= '0;
      owner_q   <= '0;
      write_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rsp_rdata <= '0;
      rsp_resp  <= 2'b00;
    end else begin
      if (grant_fire) begin
        owner_q   <= grant_idx;
        write_q   <= req_write[grant_idx];
        addr_q    <= req_addr[grant_idx*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
        wdata_q   <= req_wdata[grant_idx*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
        awvalid_q <= req_write[grant_idx];
        wvalid_q  <= req_write[grant_idx];
        arvalid_q <= !req_write[grant_idx];
        rr_ptr    <= (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
      end
      if (state == ST_ISSUE) begin
        awvalid_q <= aw_left && !timeout_fire;
        wvalid_q  <= w_left  && !timeout_fire;
        arvalid_q <= ar_left && !timeout_fire;
      end
      if (rsp_hs) begin
        rsp_resp  <= write_q ? m_axi_bresp : m_axi_rresp;
        rsp_rdata <= write_q ? '0 : m_axi_rdata;
      end else if (timeout_fire) begin
        rsp_resp  <= 2'b10;
        rsp_rdata <= '0;
      end
    end
  end

  assign rsp_valid     = (state == ST_DONE) ? (NUM_REQ'(1) << owner_q) : '0;
  assign busy          = (state != ST_IDLE);
  assign dbg_state     = state;

  assign m_axi_awaddr  = addr_q;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = '1;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = (state == ST_RESP) && write_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = (state == ST_RESP) && !write_q;

endmodule

// File: tb/tb_axi_lite_master_arbiter.sv
// tb_axi_lite_master_arbiter
// Directed bench for axi_lite_master_arbiter with NUM_REQ = 2. Inputs are
// driven and outputs sampled on the falling clock edge.
module tb_axi_lite_master_arbiter;

  localparam int NR = 2;
  localparam int AW = 32;
  localparam int DW = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic axi_areset;
  always #5 clk = ~clk;

  logic [NR-1:0]      req_valid, req_ready, req_write, rsp_valid;
  logic [NR*AW-1:0]   req_addr;
  logic [NR*DW-1:0]   req_wdata;
  logic [DW-1:0]      rsp_rdata;
  logic [1:0]         rsp_resp, dbg_state;
  logic               busy, timeout_flag;
  logic [AW-1:0]      m_axi_awaddr, m_axi_araddr;
  logic [2:0]         m_axi_awprot, m_axi_arprot;
  logic               m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic [DW-1:0]      m_axi_wdata, m_axi_rdata;
  logic [DW/8-1:0]    m_axi_wstrb;
  logic [1:0]         m_axi_bresp, m_axi_rresp;
  logic               m_axi_bvalid, m_axi_bready;
  logic               m_axi_arvalid, m_axi_arready, m_axi_rvalid, m_axi_rready;

  axi_lite_master_arbiter #(
    .NUM_REQ(NR), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .TIMEOUT_CYCLES(16)
  ) dut (
    .axi_aclk(clk), .axi_areset(axi_areset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .busy(busy), .timeout_flag(timeout_flag), .dbg_state(dbg_state),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [0:0] exp_q[$];   // expected grant order
  logic [0:0] own_q[$];   // owners awaiting a response

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    else n_pass++;
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic slave(input logic awr, input logic wr, input logic arr,
                       input logic bv, input logic rv);
    m_axi_awready = awr;
    m_axi_wready  = wr;
    m_axi_arready = arr;
    m_axi_bvalid  = bv;
    m_axi_rvalid  = rv;
  endtask

  task automatic set_cmd(input int idx, input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    req_write[idx]            = wr;
    req_addr[idx*AW +: AW]    = a;
    req_wdata[idx*DW +: DW]   = d;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int grants, rsps, last_c, bhs, waits_bad;
    logic [0:0] g, o;

    axi_areset = 1'b1;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    m_axi_bresp = 2'b00; m_axi_rresp = 2'b00; m_axi_rdata = '0;
    slave(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) step();
    axi_areset = 1'b0;
    step(); settle();

    // reset values
    check("rst_busy",      busy, 0);
    check("rst_valids",    {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid}, 0);
    check("rst_readies",   {m_axi_bready, m_axi_rready}, 0);
    check("rst_addr",      {m_axi_awaddr, m_axi_wdata}, 0);
    check("rst_rsp",       {rsp_valid, rsp_rdata, rsp_resp}, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_timeout",   timeout_flag, 0);
    check("rst_state",     dbg_state, 0);

    // single write from req 0, slave always ready
    slave(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    set_cmd(0, 1'b1, 32'h10, 32'hA5A5_5A5A);
    req_valid = 2'b01; settle();
    check("w1_grant", req_ready, 2'b01);
    step(); settle();                                  // T+1
    req_valid = '0;
    check("w1_awv_wv", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid}, 3'b110);
    check("w1_awaddr", m_axi_awaddr, 32'h10);
    check("w1_wdata",  m_axi_wdata, 32'hA5A5_5A5A);
    check("w1_wstrb",  m_axi_wstrb, 4'hF);
    check("w1_busy",   busy, 1);
    step(); settle();                                  // T+2
    check("w1_bready", {m_axi_bready, m_axi_awvalid, m_axi_wvalid}, 3'b100);
    check("w1_no_rsp", rsp_valid, 0);
    step(); settle();                                  // T+3
    check("w1_rsp_valid", rsp_valid, 2'b01);
    check("w1_rsp_data",  {rsp_rdata, rsp_resp}, 0);
    step(); settle();                                  // T+4
    check("w1_rsp_pulse", {rsp_valid, busy}, 0);

    // read from req 1 with a slow slave
    slave(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    set_cmd(1, 1'b0, 32'h20, 32'h0);
    req_valid = 2'b10; settle();
    check("r1_grant", req_ready, 2'b10);
    step(); settle();
    req_valid = '0;
    check("r1_arvalid", {m_axi_arvalid, m_axi_awvalid, m_axi_wvalid}, 3'b100);
    check("r1_araddr",  m_axi_araddr, 32'h20);
    step(); settle();
    check("r1_rready", {m_axi_rready, m_axi_arvalid}, 2'b10);
    waits_bad = 0;
    for (int k = 0; k < 5; k++) begin
      step(); settle();
      if (rsp_valid != 0 || m_axi_rready != 1'b1) waits_bad++;
    end
    check("r1_wait", waits_bad, 0);
    m_axi_rdata = 32'hDEAD_BEEF; m_axi_rresp = 2'b00; m_axi_rvalid = 1'b1;
    step(); settle();
    m_axi_rvalid = 1'b0; m_axi_rdata = 32'h0;
    check("r1_rsp_valid", rsp_valid, 2'b10);
    check("r1_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
    check("r1_rsp_resp",  rsp_resp, 2'b00);
    step(); settle();
    check("r1_rsp_pulse", rsp_valid, 0);
    check("r1_rdata_hold", rsp_rdata, 32'hDEAD_BEEF);

    // both requesters continuously valid: grant order 0,1,0,1
    slave(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    m_axi_rdata = 32'h1234_5678;
    set_cmd(0, 1'b1, 32'h100, 32'h1111_2222);
    set_cmd(1, 1'b0, 32'h104, 32'h0);
    exp_q = '{1'b0, 1'b1, 1'b0, 1'b1};
    own_q = '{};
    grants = 0; rsps = 0; last_c = 0;
    req_valid = 2'b11;
    for (int c = 0; c < 40 && rsps < 4; c++) begin
      if (grants == 4) req_valid = '0;
      settle();
      if (req_ready != 0) begin
        g = (req_ready == 2'b10);
        if (exp_q.size() == 0) check("rr_extra_grant", req_ready, 0);
        else check("rr_order", g, exp_q.pop_front());
        if (grants > 0) check("rr_gap", c - last_c, 4);
        last_c = c;
        own_q.push_back(g);
        grants++;
      end
      if (rsp_valid != 0) begin
        if (own_q.size() == 0) check("rr_extra_rsp", rsp_valid, 0);
        else begin
          o = own_q.pop_front();
          check("rr_rsp_owner", rsp_valid, (o == 1'b1) ? 2'b10 : 2'b01);
          check("rr_rsp_rdata", rsp_rdata, (o == 1'b1) ? 32'h1234_5678 : 32'h0);
        end
        rsps++;
      end
      step();
    end
    req_valid = '0;
    check("rr_rsp_count", rsps, 4);
    check("rr_grant_count", grants, 4);
    step(); step();

    // write with awready three cycles ahead of wready
    slave(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    set_cmd(0, 1'b1, 32'h40, 32'h0BAD_F00D);
    bhs = 0;
    req_valid = 2'b01; settle();
    check("w2_grant", req_ready, 2'b01);
    step(); settle();                                  // T+1
    req_valid = '0;
    check("w2_both_valid", {m_axi_awvalid, m_axi_wvalid}, 2'b11);
    step(); settle();                                  // T+2
    check("w2_aw_drop", {m_axi_awvalid, m_axi_wvalid, m_axi_bready}, 3'b010);
    step(); settle();                                  // T+3
    check("w2_w_held", {m_axi_awvalid, m_axi_wvalid, m_axi_bready}, 3'b010);
    step(); settle();                                  // T+4
    check("w2_w_still", m_axi_wvalid, 1);
    m_axi_wready = 1'b1;
    step(); settle();                                  // T+5
    check("w2_resp_phase", {m_axi_wvalid, m_axi_bready}, 2'b01);
    m_axi_bvalid = 1'b1; m_axi_bresp = 2'b01; settle();
    bhs += int'(m_axi_bvalid && m_axi_bready);
    step(); settle();                                  // T+6
    bhs += int'(m_axi_bvalid && m_axi_bready);
    check("w2_rsp_valid", rsp_valid, 2'b01);
    check("w2_rsp_resp",  {rsp_resp, rsp_rdata}, {2'b01, 32'h0});
    m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
    step(); settle();
    check("w2_rsp_pulse", rsp_valid, 0);
    check("w2_one_b", bhs, 1);

    // reset during RESP aborts the command; pointer returns to 0
    slave(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    set_cmd(1, 1'b1, 32'h80, 32'h5555_AAAA);
    req_valid = 2'b10; settle();
    check("rst_mid_grant", req_ready, 2'b10);
    step(); settle();
    req_valid = '0;
    step(); settle();
    check("rst_mid_in_resp", m_axi_bready, 1);
    axi_areset = 1'b1;
    step(); settle();
    check("rst_mid_idle", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid,
                           m_axi_bready, m_axi_rready, busy, rsp_valid}, 0);
    axi_areset = 1'b0;
    step(); settle();
    check("rst_mid_no_rsp", rsp_valid, 0);
    set_cmd(0, 1'b1, 32'h84, 32'h0);
    req_valid = 2'b11; settle();
    check("rst_mid_ptr0", req_ready, 2'b01);
    step();
    req_valid = '0;
    m_axi_bvalid = 1'b1;
    repeat (4) step();
    m_axi_bvalid = 1'b0;
    settle();
    check("rst_mid_drain", busy, 0);

`ifdef AXI_ARB_TIMEOUT_EN
    // watchdog: slave never answers the write
    begin
      int seen;
      slave(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      set_cmd(0, 1'b1, 32'hC0, 32'h0);
      req_valid = 2'b01; settle();
      check("to_grant", req_ready, 2'b01);
      step();
      req_valid = '0;
      seen = 0;
      for (int c = 1; c < 40 && seen == 0; c++) begin
        settle();
        if (rsp_valid != 0) begin
          seen = c;
          check("to_resp", rsp_resp, 2'b10);
          check("to_rdata", rsp_rdata, 0);
          check("to_flag", timeout_flag, 1);
        end
        step();
      end
      check("to_latency", seen, 17);
      settle();
      check("to_sticky", {timeout_flag, busy}, 2'b10);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // global time limit so the bench always terminates
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got hang expected finish");
    $fatal(1);
  end

endmodule
